// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_io_ctrl
//  Description : Memory-mapped I/O block for the Riscv151 data port: UART
//                TX/RX registers plus cycle and retired-instruction counters,
//                with dmem-compatible 1-cycle registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_io_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    input  logic                  re,
    input  logic                  inst_retired,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  io_hit,
    output logic [7:0]            uart_tx_data,
    output logic                  uart_tx_valid,
    input  logic                  uart_tx_ready,
    input  logic [7:0]            uart_rx_data,
    input  logic                  uart_rx_valid,
    output logic                  uart_rx_ready
);

    localparam logic [31:0] c_addr_status  = BASE_ADDR + 32'h0000_0000;
    localparam logic [31:0] c_addr_rx_data = BASE_ADDR + 32'h0000_0004;
    localparam logic [31:0] c_addr_tx_data = BASE_ADDR + 32'h0000_0008;
    localparam logic [31:0] c_addr_cyc_cnt = BASE_ADDR + 32'h0000_0010;
    localparam logic [31:0] c_addr_ins_cnt = BASE_ADDR + 32'h0000_0014;
    localparam logic [31:0] c_addr_cnt_rst = BASE_ADDR + 32'h0000_0018;
    localparam logic [DATA_WIDTH-1:0] c_one = DATA_WIDTH'(1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } tx_state_t;

    tx_state_t             r_tx_state;
    tx_state_t             w_tx_state_nxt;
    logic [7:0]            r_tx_data;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_io_hit;
    logic [DATA_WIDTH-1:0] r_cycle_cnt;
    logic [DATA_WIDTH-1:0] r_inst_cnt;

    logic                  w_hit_status;
    logic                  w_hit_rx;
    logic                  w_hit_tx;
    logic                  w_hit_cyc;
    logic                  w_hit_ins;
    logic                  w_hit_cnt_rst;
    logic                  w_win_hit;
    logic                  w_tx_valid;
    logic                  w_tx_free;
    logic                  w_tx_accept;
    logic                  w_tx_done;
    logic                  w_cnt_clear;
    logic [DATA_WIDTH-1:0] w_rd_data;
    wire  [DATA_WIDTH-1:0] w_cycle_inc;
    wire  [DATA_WIDTH-1:0] w_inst_inc;
    wire                   w_unused_wdata;

    // Full 32-bit compare: any misaligned address simply fails to match.
    assign w_hit_status  = (addr == c_addr_status);
    assign w_hit_rx      = (addr == c_addr_rx_data);
    assign w_hit_tx      = (addr == c_addr_tx_data);
    assign w_hit_cyc     = (addr == c_addr_cyc_cnt);
    assign w_hit_ins     = (addr == c_addr_ins_cnt);
    assign w_hit_cnt_rst = (addr == c_addr_cnt_rst);
    assign w_win_hit     = w_hit_status | w_hit_rx | w_hit_tx |
                           w_hit_cyc | w_hit_ins | w_hit_cnt_rst;

    assign w_tx_valid  = (r_tx_state == S_FULL);
    assign w_tx_done   = w_tx_valid & uart_tx_ready;
    assign w_tx_free   = ~w_tx_valid | uart_tx_ready;
    assign w_tx_accept = we & w_hit_tx & w_tx_free;
    assign w_cnt_clear = we & w_hit_cnt_rst;

    assign uart_rx_ready = re & w_hit_rx & uart_rx_valid & ~rst;

    assign w_cycle_inc    = r_cycle_cnt + c_one;
    assign w_inst_inc     = r_inst_cnt + {{(DATA_WIDTH-1){1'b0}}, inst_retired};
    assign w_unused_wdata = ^wdata[DATA_WIDTH-1:8];

    // TX buffer: a write landing on a completing handshake keeps it FULL.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            S_EMPTY: begin
                if (w_tx_accept) begin
                    w_tx_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_tx_accept) begin
                    w_tx_state_nxt = S_FULL;
                end else if (w_tx_done) begin
                    w_tx_state_nxt = S_EMPTY;
                end
            end
            default: w_tx_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= S_EMPTY;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data <= 8'h00;
        end else if (w_tx_accept) begin
            r_tx_data <= wdata[7:0];
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (w_hit_status) begin
            w_rd_data = {{(DATA_WIDTH-2){1'b0}}, uart_rx_valid, w_tx_free};
        end else if (w_hit_rx) begin
            w_rd_data = {{(DATA_WIDTH-8){1'b0}}, uart_rx_data};
        end else if (w_hit_cyc) begin
            w_rd_data = r_cycle_cnt;
        end else if (w_hit_ins) begin
            w_rd_data = r_inst_cnt;
        end
    end

    // Read data holds between loads so the WB stage sees it like dmem_dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_io_hit <= 1'b0;
        end else begin
            r_io_hit <= re & w_win_hit;
            if (re) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    // A counter-clear write wins over that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst || w_cnt_clear) begin
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
        end else begin
            r_cycle_cnt <= w_cycle_inc;
            r_inst_cnt  <= w_inst_inc;
        end
    end

    assign rdata         = r_rdata;
    assign io_hit        = r_io_hit;
    assign uart_tx_data  = r_tx_data;
    assign uart_tx_valid = w_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_io_ctrl
//  Description : Directed self-checking bench for mmio_io_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_io_ctrl;

    localparam logic [31:0] c_base = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_retired;
    logic [31:0] rdata;
    logic        io_hit;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int n_checks;
    int n_errors;

    mmio_io_ctrl #(
        .BASE_ADDR (c_base),
        .DATA_WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .we           (we),
        .re           (re),
        .inst_retired (inst_retired),
        .rdata        (rdata),
        .io_hit       (io_hit),
        .uart_tx_data (uart_tx_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0;
        re = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        inst_retired = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data = 8'h00;
        tick();
        tick();
        re = 1'b1; addr = c_base + 32'h4; uart_rx_valid = 1'b1; uart_rx_data = 8'hC3;
        #1;
        n_checks++;
        if (uart_rx_ready !== 1'b0) begin
            n_errors++; $display("FAIL rx_ready_in_reset: got %b expected 0", uart_rx_ready);
        end
        tick();
        n_checks++;
        if (rdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        n_checks++;
        if (io_hit !== 1'b0) begin
            n_errors++; $display("FAIL reset_io_hit: got %b expected 0", io_hit);
        end
        n_checks++;
        if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00) begin
            n_errors++; $display("FAIL reset_tx: got valid=%b data=%h expected valid=0 data=00", uart_tx_valid, uart_tx_data);
        end
        idle();
        uart_rx_valid = 1'b0;
        uart_rx_data = 8'h00;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_status();
        uart_tx_ready = 1'b1; uart_rx_valid = 1'b0;
        re = 1'b1; addr = c_base;
        tick();
        idle();
        n_checks++;
        if (rdata !== 32'h1) begin
            n_errors++; $display("FAIL status_tx_free: got %h expected 00000001", rdata);
        end
        n_checks++;
        if (io_hit !== 1'b1) begin
            n_errors++; $display("FAIL status_io_hit: got %b expected 1", io_hit);
        end
        uart_tx_ready = 1'b0; uart_rx_valid = 1'b1;
        re = 1'b1; addr = c_base;
        tick();
        idle();
        uart_rx_valid = 1'b0;
        n_checks++;
        if (rdata !== 32'h3) begin
            n_errors++; $display("FAIL status_rx_valid: got %h expected 00000003", rdata);
        end
        tick();
        n_checks++;
        if (io_hit !== 1'b0 || rdata !== 32'h3) begin
            n_errors++; $display("FAIL status_hold: got hit=%b rdata=%h expected hit=0 rdata=00000003", io_hit, rdata);
        end
    endtask

    task automatic test_tx_basic();
        uart_tx_ready = 1'b0;
        we = 1'b1; addr = c_base + 32'h8; wdata = 32'hFFFF_FF41;
        tick();
        idle();
        n_checks++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
            n_errors++; $display("FAIL tx_first: got valid=%b data=%h expected valid=1 data=41", uart_tx_valid, uart_tx_data);
        end
        we = 1'b1; addr = c_base + 32'h8; wdata = 32'h42;
        tick();
        idle();
        n_checks++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
            n_errors++; $display("FAIL tx_drop_full: got valid=%b data=%h expected valid=1 data=41", uart_tx_valid, uart_tx_data);
        end
        re = 1'b1; addr = c_base;
        tick();
        idle();
        n_checks++;
        if (rdata !== 32'h0) begin
            n_errors++; $display("FAIL tx_status_full: got %h expected 00000000", rdata);
        end
        uart_tx_ready = 1'b1;
        #1;
        n_checks++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
            n_errors++; $display("FAIL tx_at_handshake: got valid=%b data=%h expected valid=1 data=41", uart_tx_valid, uart_tx_data);
        end
        tick();
        uart_tx_ready = 1'b0;
        n_checks++;
        if (uart_tx_valid !== 1'b0) begin
            n_errors++; $display("FAIL tx_drain: got valid=%b expected 0", uart_tx_valid);
        end
    endtask

    task automatic test_tx_same_cycle();
        uart_tx_ready = 1'b0;
        we = 1'b1; addr = c_base + 32'h8; wdata = 32'h33;
        tick();
        uart_tx_ready = 1'b1;
        wdata = 32'h55;
        tick();
        idle();
        n_checks++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h55) begin
            n_errors++; $display("FAIL tx_write_on_handshake: got valid=%b data=%h expected valid=1 data=55", uart_tx_valid, uart_tx_data);
        end
        tick();
        uart_tx_ready = 1'b0;
        n_checks++;
        if (uart_tx_valid !== 1'b0) begin
            n_errors++; $display("FAIL tx_second_drain: got valid=%b expected 0", uart_tx_valid);
        end
    endtask

    task automatic test_rx();
        uart_rx_valid = 1'b1; uart_rx_data = 8'h7E;
        re = 1'b1; addr = c_base + 32'h4;
        #1;
        n_checks++;
        if (uart_rx_ready !== 1'b1) begin
            n_errors++; $display("FAIL rx_ready_pulse: got %b expected 1", uart_rx_ready);
        end
        tick();
        idle();
        uart_rx_valid = 1'b0; uart_rx_data = 8'h12;
        #1;
        n_checks++;
        if (uart_rx_ready !== 1'b0) begin
            n_errors++; $display("FAIL rx_ready_one_cycle: got %b expected 0", uart_rx_ready);
        end
        n_checks++;
        if (rdata !== 32'h7E || io_hit !== 1'b1) begin
            n_errors++; $display("FAIL rx_data: got rdata=%h hit=%b expected rdata=0000007e hit=1", rdata, io_hit);
        end
        re = 1'b1; addr = c_base + 32'h4;
        #1;
        n_checks++;
        if (uart_rx_ready !== 1'b0) begin
            n_errors++; $display("FAIL rx_empty_no_pulse: got %b expected 0", uart_rx_ready);
        end
        tick();
        idle();
        n_checks++;
        if (rdata !== 32'h12) begin
            n_errors++; $display("FAIL rx_empty_data: got %h expected 00000012", rdata);
        end
    endtask

    task automatic test_back_to_back();
        uart_tx_ready = 1'b0;
        re = 1'b1; we = 1'b1; addr = c_base + 32'h8; wdata = 32'h5A;
        tick();
        idle();
        n_checks++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h5A || rdata !== 32'h0 || io_hit !== 1'b1) begin
            n_errors++; $display("FAIL rw_tx_reg: got valid=%b data=%h rdata=%h hit=%b expected 1 5a 00000000 1", uart_tx_valid, uart_tx_data, rdata, io_hit);
        end
        uart_tx_ready = 1'b1;
        tick();
        uart_tx_ready = 1'b0;
        re = 1'b1; we = 1'b1; addr = c_base + 32'h4; wdata = 32'hA5;
        uart_rx_valid = 1'b1; uart_rx_data = 8'h3C;
        #1;
        n_checks++;
        if (uart_rx_ready !== 1'b1) begin
            n_errors++; $display("FAIL rw_rx_pulse: got %b expected 1", uart_rx_ready);
        end
        tick();
        idle();
        uart_rx_valid = 1'b0;
        n_checks++;
        if (rdata !== 32'h3C || uart_tx_valid !== 1'b0) begin
            n_errors++; $display("FAIL rw_rx_reg: got rdata=%h valid=%b expected rdata=0000003c valid=0", rdata, uart_tx_valid);
        end
    endtask

    task automatic test_counters();
        we = 1'b1; addr = c_base + 32'h18;
        tick();
        idle();
        for (int i = 0; i < 100; i++) begin
            inst_retired = ((i % 5) < 3);
            tick();
        end
        idle();
        re = 1'b1; addr = c_base + 32'h10;
        tick();
        n_checks++;
        if (rdata !== 32'd100) begin
            n_errors++; $display("FAIL cycle_count: got %0d expected 100", rdata);
        end
        addr = c_base + 32'h14;
        tick();
        idle();
        n_checks++;
        if (rdata !== 32'd60) begin
            n_errors++; $display("FAIL inst_count: got %0d expected 60", rdata);
        end
        we = 1'b1; addr = c_base + 32'h18; wdata = 32'hDEAD_BEEF; inst_retired = 1'b1;
        tick();
        idle();
        re = 1'b1; addr = c_base + 32'h10;
        tick();
        n_checks++;
        if (rdata !== 32'd0) begin
            n_errors++; $display("FAIL cycle_after_clear: got %0d expected 0", rdata);
        end
        addr = c_base + 32'h14;
        tick();
        n_checks++;
        if (rdata !== 32'd0) begin
            n_errors++; $display("FAIL inst_clear_overrides: got %0d expected 0", rdata);
        end
        addr = c_base + 32'h10;
        tick();
        idle();
        n_checks++;
        if (rdata !== 32'd2) begin
            n_errors++; $display("FAIL cycle_resumes: got %0d expected 2", rdata);
        end
    endtask

    task automatic test_wrap();
        force dut.w_cycle_inc = 32'hFFFF_FFFF;
        tick();
        release dut.w_cycle_inc;
        re = 1'b1; addr = c_base + 32'h10;
        tick();
        n_checks++;
        if (rdata !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL cycle_at_max: got %h expected ffffffff", rdata);
        end
        tick();
        idle();
        n_checks++;
        if (rdata !== 32'h0) begin
            n_errors++; $display("FAIL cycle_wrap: got %h expected 00000000", rdata);
        end
    endtask

    task automatic test_unmapped();
        uart_tx_ready = 1'b1;
        re = 1'b1; addr = c_base;
        tick();
        uart_tx_ready = 1'b0;
        re = 1'b1; we = 1'b1; addr = c_base + 32'h20; wdata = 32'h61;
        uart_rx_valid = 1'b1; uart_rx_data = 8'h9A;
        #1;
        n_checks++;
        if (uart_rx_ready !== 1'b0) begin
            n_errors++; $display("FAIL unmapped_rx_pulse: got %b expected 0", uart_rx_ready);
        end
        tick();
        n_checks++;
        if (rdata !== 32'h0 || uart_tx_valid !== 1'b0) begin
            n_errors++; $display("FAIL unmapped_access: got rdata=%h valid=%b expected 00000000 0", rdata, uart_tx_valid);
        end
        we = 1'b0; addr = c_base + 32'h5;
        #1;
        n_checks++;
        if (uart_rx_ready !== 1'b0) begin
            n_errors++; $display("FAIL misaligned_rx_pulse: got %b expected 0", uart_rx_ready);
        end
        tick();
        n_checks++;
        if (rdata !== 32'h0 || io_hit !== 1'b0) begin
            n_errors++; $display("FAIL misaligned_read: got rdata=%h hit=%b expected 00000000 0", rdata, io_hit);
        end
        re = 1'b0; we = 1'b1; addr = c_base + 32'hA; wdata = 32'h62;
        tick();
        idle();
        uart_rx_valid = 1'b0;
        n_checks++;
        if (uart_tx_valid !== 1'b0) begin
            n_errors++; $display("FAIL misaligned_write: got valid=%b expected 0", uart_tx_valid);
        end
    endtask

    task automatic test_reset_mid();
        uart_tx_ready = 1'b1;
        re = 1'b1; addr = c_base;
        tick();
        uart_tx_ready = 1'b0;
        re = 1'b0; we = 1'b1; addr = c_base + 32'h8; wdata = 32'h77;
        tick();
        idle();
        n_checks++;
        if (uart_tx_valid !== 1'b1 || rdata !== 32'h1) begin
            n_errors++; $display("FAIL pre_reset_state: got valid=%b rdata=%h expected 1 00000001", uart_tx_valid, rdata);
        end
        rst = 1'b1;
        re = 1'b1; addr = c_base;
        tick();
        idle();
        rst = 1'b0;
        n_checks++;
        if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00 || rdata !== 32'h0 || io_hit !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset: got valid=%b data=%h rdata=%h hit=%b expected 0 00 00000000 0", uart_tx_valid, uart_tx_data, rdata, io_hit);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_status();
        test_tx_basic();
        test_tx_same_cycle();
        test_rx();
        test_back_to_back();
        test_counters();
        test_wrap();
        test_unmapped();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O controller between the Riscv151 MEM stage and the on-chip UART, plus performance counters.
- Decodes data-side load/store addresses in the I/O window.
- Buffers one TX byte with a ready/valid handshake to the UART.
- Consumes RX bytes on read and returns registered read data with 1-cycle latency, matching dmem, so the WB mux treats it like dmem_dout.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the I/O window; registers sit at fixed offsets from it.
- DATA_WIDTH, 32, CPU data bus width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  MEM-stage data address (ALU result).
- wdata  in  32  store data (rs2, unshifted).
- we  in  1  store strobe for this cycle.
- re  in  1  load strobe for this cycle.
- inst_retired  in  1  one pulse per retired (non-bubble) instruction.
- rdata  out  32  registered read data, valid the cycle after re.
- io_hit  out  1  registered: previous-cycle access hit the I/O window (WB mux select).
- uart_tx_data  out  8  byte to UART.
- uart_tx_valid  out  1  TX byte pending.
- uart_tx_ready  in  1  UART can accept a byte.
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  UART holds a received byte.
- uart_rx_ready  out  1  consume RX byte (combinational pulse).

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Register map (word offsets from BASE_ADDR):
  - +0x00 status R: {30'b0, uart_rx_valid, tx_free}, where tx_free = ~tx_valid_q | uart_tx_ready.
  - +0x04 RX data R: {24'b0, uart_rx_data}.
  - +0x08 TX data W: byte = wdata[7:0].
  - +0x10 cycle counter R.
  - +0x14 instruction counter R.
  - +0x18 counter reset W (data ignored).
- Decode is a full 32-bit address match; addr[1:0] must be 00.
- Non-matching or misaligned access: no side effects; a read returns 0 next cycle.
- Reset: rdata = 0, io_hit = 0, uart_tx_valid = 0, uart_tx_data = 0, both counters 0; uart_rx_ready is held 0 while rst.
- Read latency: re at cycle N loads rdata at edge N+1. rdata holds its value until the next re.
- io_hit at N+1 = re & window hit at N.
- RX consume: uart_rx_ready = re & hit(+0x04) & uart_rx_valid & ~rst, combinational in cycle N.
  - rdata captures uart_rx_data from cycle N.
  - RX read with uart_rx_valid = 0 returns the current uart_rx_data zero-extended and does not pulse uart_rx_ready.
- TX buffer is one entry, state EMPTY/FULL held in tx_valid_q (= uart_tx_valid).
  - FULL -> EMPTY on uart_tx_valid & uart_tx_ready.
  - EMPTY -> FULL on an accepted write.
  - A write to +0x08 is accepted iff tx_free; on accept, tx_data_q <= wdata[7:0] and tx_valid_q <= 1.
  - Write in the same cycle as a completing handshake: new byte accepted, valid stays 1 (FULL -> FULL).
  - Write while FULL and uart_tx_ready = 0: silently dropped; the buffered byte is unchanged. Software polls status bit 0.
  - uart_tx_data stays stable while uart_tx_valid = 1 and not handshaken.
- Cycle counter: +1 every cycle out of reset, wraps 0xFFFF_FFFF -> 0.
- Instruction counter: +1 per cycle with inst_retired = 1, wraps likewise.
- Counter reset write at N: both counters read 0 after edge N+1, overriding that cycle's increment. Counting resumes the following cycle.
- Read of a counter at N returns its pre-edge value at N.
- we and re both asserted: both are honoured (a read of +0x04 consumes; a write to +0x08 enqueues).
- Reset mid-operation: a pending TX byte is discarded; an in-flight read returns 0.

Test Plan:
- Reset, then read +0x00 with uart_tx_ready = 1, uart_rx_valid = 0 -> rdata = 0x0000_0001 next cycle, io_hit = 1.
- Write 0x41 to +0x08 with uart_tx_ready = 0 -> uart_tx_valid = 1, data 0x41; a second write of 0x42 is dropped. Raise ready for 1 cycle -> valid drops, data still 0x41 at the handshake.
- Buffer FULL, uart_tx_ready = 1, write 0x55 in the same cycle -> handshake of old byte, uart_tx_valid stays 1, uart_tx_data = 0x55.
- uart_rx_valid = 1, rx_data = 0x7E, read +0x04 -> uart_rx_ready pulses exactly 1 cycle, rdata = 0x0000_007E. Read again with rx_valid = 0 -> no pulse.
- Run 100 cycles with inst_retired on 60 of them, read +0x10/+0x14 -> exact expected counts. Write +0x18 -> next reads return small values counted from 0.
- Force cycle counter to 0xFFFF_FFFF (run or preload), one cycle later read -> wraps to 0. Read 0x8000_0020 -> rdata = 0, no side effects.
